// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. It latches a and b when start is seen in IDLE,
//   then adds one bit per clock, LSB first, for N clocks. After that it presents
//   the registered {cout, sum} and pulses done for one cycle.
//
//   Timeline:
//     E0         start sampled in IDLE, operands latched, go to RUN
//     E1..EN     one result bit per edge
//     EN         sum/cout loaded, go to DONE
//     EN+1       back to IDLE; a start can be taken at EN+2 at the earliest
//
//   Ports:
//     clk    in   single clock, rising edge
//     rst    in   asynchronous, active-high reset
//     start  in   begin an addition (taken only in IDLE)
//     a, b   in   N-bit unsigned operands
//     busy   out  high in RUN and DONE
//     done   out  one-cycle pulse; sum/cout are valid from this cycle on
//     sum    out  registered (a + b) mod 2^N; changes only on entry to DONE
//     cout   out  registered carry out (bit N of a + b)
// -----------------------------------------------------------------------------

// One-bit full adder cell used by the serial datapath.
//   i_a, i_b, i_c : addend bits and carry in
//   o_s, o_c      : sum bit and carry out (majority)
module serial_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Wide enough to hold N, so the counter cannot wrap during an operation.
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [N-1:0]   r_a;       // operand shift registers; bit 0 is the current bit
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_res;     // result bits enter at the MSB and shift toward the LSB
  logic           r_c;       // running carry
  logic [CW-1:0]  r_cnt;     // number of bits already produced in this RUN

  logic           w_bit;
  logic           w_c_nxt;
  logic           w_last;
  logic [N-1:0]   w_res_nxt;

  serial_adder_fa u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_c),
    .o_s (w_bit),
    .o_c (w_c_nxt)
  );

  // The bit being produced now is the last one (bit N-1).
  assign w_last = (r_cnt == CW'(N - 1));

  // Shift the new bit in at the top. After N shifts, bit 0 has reached the LSB.
  // The shift is written as a shift followed by a bit set, so N=1 needs no
  // special case.
  always_comb begin
    w_res_nxt        = r_res >> 1;
    w_res_nxt[N-1]   = w_bit;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Operands are captured only here, so later changes on a/b have no
          // effect. The carry starts at 0 for every operation.
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c_nxt;
          r_res <= w_res_nxt;
          r_cnt <= r_cnt + CW'(1);
          // Outputs update only here, so partial results never appear on them.
          if (w_last) begin
            sum   <= w_res_nxt;
            cout  <= w_c_nxt;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand and result width in bits; legal range N >= 1.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL have port a  input  N  first operand, unsigned.
REQ-006 SHALL have port b  input  N  second operand, unsigned.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (states RUN and DONE).
REQ-008 SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-009 SHALL have port sum  output  N  registered result, (a + b) mod 2^N.
REQ-010 SHALL have port cout  output  1  registered carry out, bit N of a + b.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE: busy=0, done=0; start=1 sampled at edge E0 latches a and b into internal operand shift registers, clears carry and bit counter, and moves to RUN.
REQ-013 RUN: one bit per cycle, LSB first; at edge Ek (k=1..N) it computes bit k-1 as a^b^c, updates carry as majority(a,b,c), and shifts the bit into the internal result register.
REQ-014 RUN SHALL last exactly N cycles; the bit counter is ceil(log2(N+1)) bits wide and never wraps mid-operation.
REQ-015 At edge EN, sum SHALL load the full internal result, cout SHALL load the final carry, and the state SHALL move to DONE.
REQ-016 DONE: done=1 for exactly one cycle, busy=1; at the next edge the state SHALL return to IDLE.
REQ-017 Latency SHALL be fixed: done is high in the cycle following edge EN, i.e. N+1 cycles after the start-sampling edge.
REQ-018 sum and cout SHALL change only at the RUN-to-DONE edge; they hold their value through IDLE and the next RUN, so partial results are never visible.
REQ-019 Changes on a or b after E0 SHALL NOT affect the operation in progress.
REQ-020 start SHALL be ignored in RUN and DONE; it is accepted only in IDLE, so start held high continuously gives back-to-back operations with one IDLE cycle between DONE and the next RUN.
REQ-021 The carry into bit 0 SHALL be 0; no carry is chained between operations.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force the state to IDLE and clear busy, done, sum, cout, carry, counter and internal registers to 0.
REQ-023 rst asserted during RUN or DONE SHALL abort the operation; no done pulse is produced for it.
REQ-024 After rst deasserts, the first rising edge with start=1 SHALL begin a new operation normally.

Verification
REQ-025 N=4, a=0010, b=0001, start pulse -> busy high for 5 cycles, done high 5 cycles after the start edge, sum=0011, cout=0.
REQ-026 a=1111, b=0001 -> sum=0000, cout=1; then a=1111, b=1111 -> sum=1110, cout=1; then a=0000, b=0000 -> sum=0000, cout=0.
REQ-027 Start a=0010, b=0011, then change a=1111 and b=1111 and pulse start during RUN -> sum=0101, cout=0, exactly one done pulse, no extra operation.
REQ-028 Hold start=1 with a=0001, b=0001 for 15 cycles -> done pulses spaced every N+2=6 cycles, sum=0010 each time, and sum stays stable between pulses.
REQ-029 Assert rst between clock edges in the third RUN cycle -> outputs go to 0 at once, no done pulse; a following start with a=0111, b=0001 -> sum=1000, cout=0.
REQ-030 Exhaustive check for N=4 (all 256 a,b pairs) -> {cout,sum} equals a+b for every pair.
